// File: rtl/tt_tdc_tdl_seq.sv
// Sequenced tapped-delay-line TDC: carry-chain delay line, pulse-source mux, two-flop tap
// synchroniser and a sequencer that accumulates sum/min/max over 2**N_SAMP_W samples.
module tt_tdc_tdl_seq #(
    parameter int    LEN_POP_OUT = 6,
    parameter int    DL_LEN      = 2**LEN_POP_OUT,
    parameter string DL_TYPE     = "ADD",
    parameter int    N_SAMP_W    = 4
) (
    input  logic                                clk_launch,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                start,
    input  logic [1:0]                          sel,
    input  logic                                pg_in,
    input  logic                                pg_tog,
    input  logic                                pg_bypass,
    output logic                                busy,
    output logic                                meas_valid,
    input  logic                                meas_ready,
    output logic [LEN_POP_OUT+N_SAMP_W:0]       meas_sum,
    output logic [LEN_POP_OUT:0]                meas_min,
    output logic [LEN_POP_OUT:0]                meas_max,
    output logic                                meas_ovf,
    output logic [DL_LEN-1:0]                   dl_taps
);
    localparam int POP_W = LEN_POP_OUT + 1;
    localparam int SUM_W = POP_W + N_SAMP_W;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_LAUNCH, S_CAP, S_ACC, S_DONE
    } state_t;

    if (DL_TYPE != "ADD") begin : g_bad_type
        $error("tt_tdc_tdl_seq: unsupported DL_TYPE");
    end

    state_t              state;
    logic                launch_q, tog_q, pol_q, byp_q;
    logic [1:0]          sel_q;
    logic                chain_in;
    logic [DL_LEN:0]     c;
    logic [DL_LEN-1:0]   tap_q1, tap_q2;
    logic [SUM_W-1:0]    acc_sum;
    logic [POP_W-1:0]    acc_min, acc_max, pop;
    logic                acc_ovf;
    logic [N_SAMP_W-1:0] cnt;

    always_comb begin
        chain_in = 1'b0;
        unique case (sel_q)
            2'b00:   chain_in = launch_q;
            2'b01:   chain_in = pg_in;
            2'b10:   chain_in = tog_q;
            default: chain_in = 1'b0;
        endcase
    end

    assign c[0] = chain_in;
    for (genvar i = 0; i < DL_LEN; i++) begin : g_cell
        // Carry cell with A=1, B=0: carry out follows carry in, so the edge ripples along.
        localparam logic A = 1'b1;
        localparam logic B = 1'b0;
        assign c[i+1] = (A & B) | (c[i] & (A ^ B));
    end

    // A plain ones count; bubbles in the thermometer code just add or subtract single taps.
    function automatic logic [POP_W-1:0] popcount(input logic [DL_LEN-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < DL_LEN; i++) n = n + POP_W'(v[i]);
        return n;
    endfunction

    assign pop     = popcount(pol_q ? tap_q2 : ~tap_q2);
    assign dl_taps = tap_q2;

    always_ff @(posedge clk_launch) begin
        if (rst) begin
            state      <= S_IDLE;
            launch_q   <= 1'b0;
            tog_q      <= 1'b0;
            pol_q      <= 1'b0;
            byp_q      <= 1'b0;
            sel_q      <= 2'b00;
            tap_q1     <= '0;
            tap_q2     <= '0;
            acc_sum    <= '0;
            acc_min    <= '0;
            acc_max    <= '0;
            acc_ovf    <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            meas_sum   <= '0;
            meas_min   <= '0;
            meas_max   <= '0;
            meas_ovf   <= 1'b0;
        end else begin
            tap_q1 <= c[DL_LEN:1];
            tap_q2 <= tap_q1;
            tog_q  <= pg_tog;
            if (!en) begin
                state      <= S_IDLE;
                busy       <= 1'b0;
                meas_valid <= 1'b0;
                launch_q   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state   <= S_SETTLE;
                            busy    <= 1'b1;
                            sel_q   <= sel;
                            byp_q   <= pg_bypass;
                            acc_sum <= '0;
                            acc_min <= POP_W'(DL_LEN);
                            acc_max <= '0;
                            acc_ovf <= 1'b0;
                            cnt     <= '0;
                            if (!pg_bypass) launch_q <= 1'b0;
                        end
                    end
                    S_SETTLE: begin
                        state <= S_LAUNCH;
                        // In toggle mode the launched level alternates; pol_q records it so
                        // falling launches are counted on the inverted taps.
                        if (byp_q) launch_q <= ~launch_q;
                        else       launch_q <= 1'b1;
                        pol_q <= (sel_q != 2'b00) | (byp_q ? ~launch_q : 1'b1);
                    end
                    S_LAUNCH: state <= S_CAP;
                    S_CAP:    state <= S_ACC;
                    S_ACC: begin
                        acc_sum <= acc_sum + SUM_W'(pop);
                        if (pop < acc_min) acc_min <= pop;
                        if (pop > acc_max) acc_max <= pop;
                        if (pop == POP_W'(DL_LEN)) acc_ovf <= 1'b1;
                        cnt <= cnt + N_SAMP_W'(1);
                        if (&cnt) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_SETTLE;
                            if (!byp_q) launch_q <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        // First DONE cycle publishes the accumulators; then wait for the consumer.
                        if (!meas_valid) begin
                            meas_valid <= 1'b1;
                            meas_sum   <= acc_sum;
                            meas_min   <= acc_min;
                            meas_max   <= acc_max;
                            meas_ovf   <= acc_ovf;
                        end else if (meas_ready) begin
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            meas_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tt_tdc_tdl_seq.sv
// Self-checking bench for tt_tdc_tdl_seq: directed scenarios plus randomized measurements
// compared against a per-sample popcount model.
module tb_tt_tdc_tdl_seq;
    localparam int NS  = 16;
    localparam int DLL = 64;

    logic        clk = 1'b0;
    logic        rst, en, start, pg_in, pg_tog, pg_bypass, meas_ready;
    logic [1:0]  sel;
    logic        busy, meas_valid, meas_ovf;
    logic [10:0] meas_sum;
    logic [6:0]  meas_min, meas_max;
    logic [63:0] dl_taps;

    int n_checks = 0;
    int n_bad    = 0;

    logic [6:0]  exp_q[$];
    logic        model_launch;
    logic [10:0] last_sum;
    logic [6:0]  last_min, last_max;
    logic        last_ovf;

    tt_tdc_tdl_seq dut (
        .clk_launch(clk), .rst(rst), .en(en), .start(start), .sel(sel),
        .pg_in(pg_in), .pg_tog(pg_tog), .pg_bypass(pg_bypass),
        .busy(busy), .meas_valid(meas_valid), .meas_ready(meas_ready),
        .meas_sum(meas_sum), .meas_min(meas_min), .meas_max(meas_max),
        .meas_ovf(meas_ovf), .dl_taps(dl_taps)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: a sample's popcount is the whole chain when the selected source is
    // at its launched level, else zero; internal launches always fill the chain.
    function automatic logic [6:0] model_pop(input logic [1:0] s, input logic lv);
        case (s)
            2'b00:   return 7'(DLL);
            2'b01,
            2'b10:   return lv ? 7'(DLL) : 7'd0;
            default: return 7'd0;
        endcase
    endfunction

    task automatic check_hold(input string tag);
        check_val({tag, "_sum"}, 64'(meas_sum), 64'(last_sum));
        check_val({tag, "_min"}, 64'(meas_min), 64'(last_min));
        check_val({tag, "_max"}, 64'(meas_max), 64'(last_max));
        check_val({tag, "_ovf"}, 64'(meas_ovf), 64'(last_ovf));
    endtask

    // Runs one full measurement; called right after a negedge with the DUT idle.
    task automatic run_meas(input string tag, input logic [1:0] s, input logic b,
                            input int rdy_wait, input logic rnd_lvl, input logic chk_taps);
        logic lv[NS];
        logic l0;
        int   k;
        exp_q.delete();
        for (int i = 0; i < NS; i++) begin
            lv[i] = rnd_lvl ? 1'($urandom_range(0, 1)) : 1'b1;
            exp_q.push_back(model_pop(s, lv[i]));
        end
        l0 = model_launch;
        sel = s; pg_bypass = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= 4 * NS + 1; e++) begin
            if (((e - 1) % 4) == 0 && ((e - 1) / 4) < NS) begin
                k = (e - 1) / 4;
                pg_in  = (s == 2'b10) ? ~lv[k] : lv[k];
                pg_tog = (s == 2'b01) ? ~lv[k] : lv[k];
            end
            @(negedge clk);
            if (chk_taps && (e % 4) == 3) begin
                k = (e - 3) / 4;
                check_val({tag, "_taps"}, dl_taps, (k % 2 == 0) ? {64{~l0}} : {64{l0}});
            end
            if (e == 4 * NS) begin
                check_val({tag, "_valid_early"}, 64'(meas_valid), 64'd0);
                check_val({tag, "_busy"}, 64'(busy), 64'd1);
            end
        end
        last_sum = '0; last_min = 7'(DLL); last_max = '0; last_ovf = 1'b0;
        foreach (exp_q[i]) begin
            last_sum += 11'(exp_q[i]);
            if (exp_q[i] < last_min) last_min = exp_q[i];
            if (exp_q[i] > last_max) last_max = exp_q[i];
            if (exp_q[i] == 7'(DLL)) last_ovf = 1'b1;
        end
        check_val({tag, "_valid"}, 64'(meas_valid), 64'd1);
        check_hold(tag);
        for (int w = 0; w < rdy_wait; w++) begin
            start = 1'b1;
            sel = ~sel;
            @(negedge clk);
            check_val({tag, "_wait_valid"}, 64'(meas_valid), 64'd1);
            check_val({tag, "_wait_busy"}, 64'(busy), 64'd1);
            check_hold({tag, "_wait"});
        end
        start = 1'b0;
        meas_ready = 1'b1;
        @(negedge clk);
        meas_ready = 1'b0;
        check_val({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_idle_valid"}, 64'(meas_valid), 64'd0);
        if (!b) model_launch = 1'b1;
    endtask

    initial begin
        logic saw_valid;
        rst = 1'b1; en = 1'b0; start = 1'b0; sel = 2'b00; pg_in = 1'b0; pg_tog = 1'b0;
        pg_bypass = 1'b0; meas_ready = 1'b0;
        model_launch = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_valid", 64'(meas_valid), 64'd0);
        check_val("rst_sum", 64'(meas_sum), 64'd0);
        check_val("rst_taps", dl_taps, 64'd0);
        rst = 1'b0; en = 1'b1;
        @(negedge clk);

        run_meas("zero_cal", 2'b11, 1'b0, 0, 1'b0, 1'b0);
        check_val("zero_cal_sum_abs", 64'(meas_sum), 64'd0);
        run_meas("internal", 2'b00, 1'b0, 0, 1'b0, 1'b0);
        check_val("internal_sum_abs", 64'(meas_sum), 64'd1024);
        run_meas("toggle", 2'b00, 1'b1, 0, 1'b0, 1'b1);
        check_val("toggle_sum_abs", 64'(meas_sum), 64'd1024);
        run_meas("stall", 2'b01, 1'b0, 10, 1'b1, 1'b0);

        // Abort by dropping en during sample 7.
        sel = 2'b01; pg_in = 1'b1; pg_bypass = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (28) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_valid", 64'(meas_valid), 64'd0);
        check_hold("abort_hold");
        saw_valid = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (meas_valid) saw_valid = 1'b1;
        end
        check_val("abort_no_valid", 64'(saw_valid), 64'd0);
        en = 1'b1; model_launch = 1'b0;
        @(negedge clk);
        run_meas("after_abort", 2'b00, 1'b0, 1, 1'b0, 1'b0);

        // Reset while in CAP of sample 5.
        sel = 2'b01; pg_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (22) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_valid", 64'(meas_valid), 64'd0);
        check_val("midrst_sum", 64'(meas_sum), 64'd0);
        check_val("midrst_max", 64'(meas_max), 64'd0);
        check_val("midrst_taps", dl_taps, 64'd0);
        model_launch = 1'b0;
        run_meas("after_rst", 2'b01, 1'b0, 0, 1'b0, 1'b0);
        check_val("after_rst_sum_abs", 64'(meas_sum), 64'd1024);

        for (int r = 0; r < 8; r++) begin
            run_meas($sformatf("rnd%0d", r), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
